// File: rtl/core_wishbone_master_pkg.sv
// Shared definitions for the core-side Wishbone master: state encoding and
// the value returned for reads that never complete on the bus.
package core_wishbone_master_pkg;

    typedef logic [1:0] state_t;

    localparam state_t STATE_IDLE = 2'b00;
    localparam state_t STATE_BUS  = 2'b01;
    localparam state_t STATE_DONE = 2'b10;

    // Same value the memory controller returns for unmapped reads.
    localparam logic [31:0] BUS_ERROR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/core_wishbone_master.sv
// Turns a held core memory request into one classic Wishbone cycle, with a
// timeout so a missing slave cannot hang the core.
module core_wishbone_master
    import core_wishbone_master_pkg::*;
#(
    parameter logic [3:0]  ADDRESS_PREFIX = 4'b0001,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] wbAddress,
    input  logic [3:0]  wbByteSelect,
    input  logic        wbWriteEnable,
    input  logic        wbReadEnable,
    input  logic [31:0] wbDataWrite,
    output logic [31:0] wbDataRead,
    output logic        wbBusy,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic        timeoutError
);

    localparam int unsigned   CW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout_q, timeout_d;

    logic request;
    logic ack_done;
    logic timeout_done;

    assign request      = wbReadEnable | wbWriteEnable;
    assign ack_done     = (state_q == STATE_BUS) && wb_ack_i;
    // Ack wins over an expiring counter on the same cycle.
    assign timeout_done = (state_q == STATE_BUS) && !wb_ack_i && (count_q == LAST_COUNT);
    assign wbBusy       = request && (state_q != STATE_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            STATE_IDLE: begin
                if (request) begin
                    state_d = STATE_BUS;
                    count_d = '0;
                end
            end
            STATE_BUS: begin
                if (ack_done || timeout_done) begin
                    state_d = STATE_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            STATE_DONE: state_d = STATE_IDLE;
            default:    state_d = STATE_IDLE;
        endcase
    end

    // Bus-side fields are captured only when a cycle starts and held afterwards.
    always_comb begin
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = 1'b0;
        if ((state_q == STATE_IDLE) && request) begin
            cyc_d   = 1'b1;
            we_d    = wbWriteEnable;
            sel_d   = wbByteSelect;
            adr_d   = {ADDRESS_PREFIX, wbAddress};
            wdata_d = wbDataWrite;
        end else if (ack_done) begin
            cyc_d = 1'b0;
            if (!we_q) begin
                rdata_d = wb_data_i;
            end
        end else if (timeout_done) begin
            cyc_d     = 1'b0;
            timeout_d = 1'b1;
            if (!we_q) begin
                rdata_d = BUS_ERROR_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_adr_o     = adr_q;
    assign wb_data_o    = wdata_q;
    assign wbDataRead   = rdata_q;
    assign timeoutError = timeout_q;

endmodule

// File: tb/tb_core_wishbone_master.sv
// Randomised bench: a driver issues requests and plays the Wishbone slave,
// a monitor checks each completed request against a queued expectation.
module tb_core_wishbone_master;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] wbAddress = '0;
    logic [3:0]  wbByteSelect = '0;
    logic        wbWriteEnable = 1'b0;
    logic        wbReadEnable = 1'b0;
    logic [31:0] wbDataWrite = '0;
    logic [31:0] wbDataRead;
    logic        wbBusy;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_data_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        timeoutError;

    core_wishbone_master #(
        .ADDRESS_PREFIX(4'b0001),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wbAddress    (wbAddress),
        .wbByteSelect (wbByteSelect),
        .wbWriteEnable(wbWriteEnable),
        .wbReadEnable (wbReadEnable),
        .wbDataWrite  (wbDataWrite),
        .wbDataRead   (wbDataRead),
        .wbBusy       (wbBusy),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_adr_o     (wb_adr_o),
        .wb_data_o    (wb_data_o),
        .wb_data_i    (wb_data_i),
        .wb_ack_i     (wb_ack_i),
        .timeoutError (timeoutError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        tmo;
        int          busy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b1;
    logic [31:0] last_read = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a held request with busy low marks completion.
    initial begin
        int busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                busy_cnt = 0;
            end else if ((wbReadEnable || wbWriteEnable) && !wbBusy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got completion expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", wbDataRead, e.rdata);
                    check("timeout_pulse", {31'b0, timeoutError}, {31'b0, e.tmo});
                    check("busy_cycles", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end else begin
                if ((wbReadEnable || wbWriteEnable) && wbBusy) busy_cnt++;
                check("timeout_quiet", {31'b0, timeoutError}, 32'd0);
            end
        end
    end

    // One request; d is the bus cycle index carrying ack (d >= T means no ack).
    task automatic txn(input bit sync, input logic [27:0] a, input logic [3:0] s,
                       input logic w, input logic r, input logic [31:0] wd,
                       input logic [31:0] rv, input int d);
        exp_t e;
        int   waits;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        wbAddress = a;
        wbByteSelect = s;
        wbWriteEnable = w;
        wbReadEnable = r;
        wbDataWrite = wd;
        if (!w) last_read = (d < T) ? rv : 32'hFFFF_FFFF;
        e.rdata = last_read;
        e.tmo   = (d >= T);
        e.busy  = 1 + ((d < T) ? d + 1 : T);
        exp_q.push_back(e);
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!wb_cyc_o && waits < 6);
        check("cyc_start", waits, 2);
        check("adr", wb_adr_o, {4'b0001, a});
        check("we", {31'b0, wb_we_o}, {31'b0, w});
        check("sel", {28'b0, wb_sel_o}, {28'b0, s});
        check("wdata", wb_data_o, wd);
        check("stb", {31'b0, wb_stb_o}, 32'd1);
        for (int i = 0; i < T; i++) begin
            if (i > 0) check("cyc_held", {31'b0, wb_cyc_o}, 32'd1);
            #1;
            wb_ack_i  = (i == d);
            wb_data_i = (i == d) ? rv : $urandom;
            @(negedge clk);
            if (i == d) break;
        end
        check("cyc_drop", {31'b0, wb_cyc_o}, 32'd0);
        #1;
        wb_ack_i = 1'b0;
    endtask

    // Either keep the request for a back-to-back access or go idle with ack noise.
    task automatic after(input bit b2b);
        if (!b2b) begin
            @(posedge clk);
            #1;
            wbReadEnable = 1'b0;
            wbWriteEnable = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                wb_ack_i = 1'($urandom);
                @(posedge clk);
                #1;
            end
            wb_ack_i = 1'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int waits;
        @(negedge clk);
        check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        check("rst_we", {31'b0, wb_we_o}, 32'd0);
        check("rst_sel", {28'b0, wb_sel_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_wdata", wb_data_o, 32'd0);
        check("rst_rdata", wbDataRead, 32'd0);
        check("rst_timeout", {31'b0, timeoutError}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        txn(1, 28'h000_0010, 4'hF, 0, 1, 32'h0, 32'hDEAD_BEEF, 2);
        after(0);
        txn(1, 28'h000_0F04, 4'b0011, 1, 0, 32'h1234_5678, 32'h0BAD_0BAD, 0);
        after(0);
        txn(1, 28'h000_0100, 4'hF, 0, 1, 32'h0, 32'h5555_AAAA, T);
        after(0);
        txn(1, 28'h000_0030, 4'hF, 0, 1, 32'h0, 32'h1111_2222, 1);
        after(1);
        txn(1, 28'h000_0020, 4'hF, 0, 1, 32'h0, 32'h3333_4444, 1);
        after(0);
        txn(1, 28'h000_0040, 4'hF, 0, 1, 32'h0, 32'hCAFE_F00D, T - 1);
        after(0);

        for (int k = 0; k < 40; k++) begin
            int op;
            op = $urandom_range(0, 2);
            txn(1, 28'($urandom), 4'($urandom), op != 0, op != 1, $urandom, $urandom,
                $urandom_range(0, T + 1));
            after(1'($urandom));
        end

        txn(1, 28'h000_0050, 4'hF, 0, 1, 32'h0, 32'hA5A5_0F0F, 1);
        after(0);

        // Reset in the middle of a bus cycle, request kept asserted.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        wb_ack_i = 1'b0;
        wbAddress = 28'h000_0ABC;
        wbByteSelect = 4'hF;
        wbReadEnable = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!wb_cyc_o && waits < 6);
        check("pre_rst_cyc", {31'b0, wb_cyc_o}, 32'd1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("async_rst_stb", {31'b0, wb_stb_o}, 32'd0);
        check("async_rst_rdata", wbDataRead, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        last_read = '0;
        txn(0, 28'h000_0ABC, 4'hF, 0, 1, 32'h0, 32'h7777_8888, 2);
        after(0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_wishbone_master.md
Name: core_wishbone_master

Overview:
- Responder for the memory controller's WB-side request port: turns a held core request (address, byte select, read/write enable, data) into a single classic Wishbone bus cycle.
- Returns read data and busy to the controller.
- Sits between the core memory controller and the SoC Wishbone interconnect, one instance per core.
- A timeout counter stops a missing slave from hanging the core.

Parameters:
- ADDRESS_PREFIX, 4'b0001, upper 4 bits prepended to the 28-bit request address to form wb_adr_o.
- TIMEOUT_CYCLES, 255, bus cycles to wait for wb_ack_i before aborting; width of the counter is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wbAddress  input  28  request byte address from the memory controller.
- wbByteSelect  input  4  request byte lanes.
- wbWriteEnable  input  1  write request, held until busy is low.
- wbReadEnable  input  1  read request, held until busy is low.
- wbDataWrite  input  32  write data.
- wbDataRead  output  32  read data, registered.
- wbBusy  output  1  request not yet complete.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  Wishbone write enable.
- wb_sel_o  output  4  Wishbone byte select.
- wb_adr_o  output  32  Wishbone address = {ADDRESS_PREFIX, latched wbAddress}.
- wb_data_o  output  32  Wishbone write data.
- wb_data_i  input  32  Wishbone read data.
- wb_ack_i  input  1  Wishbone acknowledge.
- timeoutError  output  1  one-cycle pulse when a cycle is aborted by timeout.

Behaviour:
- Reset values (asynchronous): state IDLE; wb_cyc_o, wb_stb_o, wb_we_o at 0; wb_sel_o, wb_adr_o, wb_data_o at 0; wbDataRead at 0; timeoutError at 0; timeout counter at 0.
- Reset asserted mid-cycle drops cyc/stb immediately and discards the transaction.
- Request is defined as wbReadEnable | wbWriteEnable. If both are set, the access is a write.
- wbBusy = request && state != DONE. It is combinational, so the controller sees busy in the same cycle the request appears.

State IDLE:
- On request, register adr/sel/we/data onto the bus outputs and set cyc=stb=1 on the next edge.
- Go to BUS and clear the timeout counter.

State BUS:
- Bus outputs are held stable.
- If wb_ack_i: drop cyc/stb, go to DONE.
  - For a read, capture wb_data_i into wbDataRead.
  - For a write, wbDataRead is unchanged.
- Else, if counter == TIMEOUT_CYCLES-1: drop cyc/stb, pulse timeoutError, go to DONE.
  - For a read, set wbDataRead = 32'hFFFFFFFF.
- Else increment the counter.
- Ack arriving on the same cycle the counter expires counts as ack; no timeout is flagged.

State DONE:
- wbBusy is low for exactly one cycle; the controller consumes wbDataRead in this cycle.
- Go to IDLE unconditionally. A request still held in IDLE starts a new bus cycle, so back-to-back accesses are possible.

General rules:
- Minimum latency: request at cycle 0, cyc/stb at cycle 1, ack at cycle 1 gives DONE at cycle 2, so busy is low in cycle 2.
- A request withdrawn while in BUS does not abort the Wishbone cycle; the cycle completes and its result is discarded.
- wb_ack_i outside BUS is ignored.
- wb_we_o, wb_sel_o, wb_adr_o and wb_data_o keep their last values when idle (cyc=0). Only cyc/stb qualify them.

Decomposition:
- Shared package:
  - State encoding constants STATE_IDLE=2'b00, STATE_BUS=2'b01, STATE_DONE=2'b10.
  - Bus error read value 32'hFFFFFFFF, shared with the memory controller's unmapped read value.
- No sub-module; the timeout counter is inline.

Test Plan:
- Read with ack after 3 cycles, wbAddress=28'h0000010, wb_data_i=32'hDEADBEEF:
  - wb_adr_o=32'h10000010, we=0, sel=4'hF.
  - wbBusy high 4 cycles, then low one cycle with wbDataRead=32'hDEADBEEF.
- Write with immediate ack, wbAddress=28'h0000F04, sel=4'b0011, data=32'h12345678:
  - wb_we_o=1, wb_data_o=32'h12345678.
  - cyc high exactly 1 cycle; busy low at cycle 2.
- Timeout, read with no ack and TIMEOUT_CYCLES=8:
  - cyc drops after 8 cycles, timeoutError pulses once.
  - wbDataRead=32'hFFFFFFFF, busy then low.
- Back-to-back: read held after DONE with a new address 28'h0000020:
  - A second cycle starts, cyc low for exactly DONE plus IDLE edge.
  - Both read values are returned in order.
- Simultaneous ack and timeout on the last count cycle:
  - No timeoutError; wbDataRead=wb_data_i.
- Reset asserted while in BUS with cyc=1:
  - cyc/stb/wbDataRead go to 0 asynchronously.
  - After release, a read with the request still held starts a fresh cycle.
